// File: rtl/arb_rr_param.sv
// arb_rr_param: round-robin arbiter that multiplexes NREQ requester channels
// onto a single memory-side master port.
// The winning request is registered onto the master port, and completion is
// returned only to the granted channel.
// Optional feature: define ARB_LOCK_EN to let a channel keep the grant for up
// to MAX_LOCK back-to-back transactions while it holds lock_a.
module arb_rr_param #(
  parameter int NREQ     = 4,
  parameter int AW       = 64,
  parameter int DW       = 64,
  parameter int IDXW     = $clog2(NREQ),
  parameter int MAX_LOCK = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ*AW-1:0] addr_a,
  input  logic [NREQ*DW-1:0] dout_a,
  output logic [NREQ*DW-1:0] din_a,
  input  logic [NREQ-1:0]    req_a,
  input  logic [NREQ-1:0]    wr_a,
  output logic [NREQ-1:0]    rdy_a,
  input  logic [NREQ-1:0]    lock_a,
  output logic [AW-1:0]      addr_m,
  output logic [DW-1:0]      dout_m,
  input  logic [DW-1:0]      din_m,
  output logic               req_m,
  output logic               wr_m,
  input  logic               rdy_m,
  output logic [IDXW-1:0]    grant_idx,
  output logic               busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] last_q, last_d;
  logic [IDXW-1:0] grant_idx_q, grant_idx_d;
  logic [AW-1:0]   addr_m_q, addr_m_d;
  logic [DW-1:0]   dout_m_q, dout_m_d;
  logic            wr_m_q, wr_m_d;

  logic            rr_found;
  logic [IDXW-1:0] rr_idx;
  logic [IDXW-1:0] cand;

  logic            win_valid;
  logic [IDXW-1:0] win_idx;

`ifdef ARB_LOCK_EN
  // lock_cnt counts the grants in the current run to one channel: the
  // round-robin grant that opens a run counts as 1, and each lock-priority
  // grant adds 1. Capping it at MAX_LOCK bounds a run to MAX_LOCK grants.
  localparam int LCW = $clog2(MAX_LOCK + 1);

  logic [LCW-1:0]  lock_cnt_q, lock_cnt_d;
  logic            lock_hold_q, lock_hold_d;
  logic            win_locked;
`else
  logic            unused_lock;
  assign unused_lock = ^{lock_a, MAX_LOCK[0]};
`endif

  // Round-robin search: starts one past the last completed grant and wraps.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = IDXW'((int'(last_q) + off) % NREQ);
      if (!rr_found && req_a[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // Winner selection: a held lock takes priority over round-robin order.
  always_comb begin
    win_valid = rr_found;
    win_idx   = rr_idx;
`ifdef ARB_LOCK_EN
    win_locked = 1'b0;
    if (lock_hold_q && req_a[grant_idx_q]) begin
      win_valid  = 1'b1;
      win_idx    = grant_idx_q;
      win_locked = 1'b1;
    end
`endif
  end

  // Next-state logic: capture the winner in IDLE and release on rdy_m in BUSY.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_idx_d = grant_idx_q;
    addr_m_d    = addr_m_q;
    dout_m_d    = dout_m_q;
    wr_m_d      = wr_m_q;
`ifdef ARB_LOCK_EN
    lock_cnt_d  = lock_cnt_q;
    lock_hold_d = lock_hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d     = BUSY;
          grant_idx_d = win_idx;
          addr_m_d    = addr_a[win_idx*AW +: AW];
          dout_m_d    = dout_a[win_idx*DW +: DW];
          wr_m_d      = wr_a[win_idx];
`ifdef ARB_LOCK_EN
          lock_hold_d = 1'b0;
          lock_cnt_d  = win_locked ? lock_cnt_q + LCW'(1) : LCW'(1);
`endif
        end
      end
      BUSY: begin
        if (rdy_m) begin
          state_d = IDLE;
          last_d  = grant_idx_q;
`ifdef ARB_LOCK_EN
          if (lock_a[grant_idx_q] && (lock_cnt_q < LCW'(MAX_LOCK))) begin
            last_d      = last_q;
            lock_hold_d = 1'b1;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; last starts at NREQ-1 so channel 0 goes first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= IDXW'(NREQ - 1);
      grant_idx_q <= '0;
      addr_m_q    <= '0;
      dout_m_q    <= '0;
      wr_m_q      <= 1'b0;
`ifdef ARB_LOCK_EN
      lock_cnt_q  <= '0;
      lock_hold_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_idx_q <= grant_idx_d;
      addr_m_q    <= addr_m_d;
      dout_m_q    <= dout_m_d;
      wr_m_q      <= wr_m_d;
`ifdef ARB_LOCK_EN
      lock_cnt_q  <= lock_cnt_d;
      lock_hold_q <= lock_hold_d;
`endif
    end
  end

  // Completion goes only to the granted channel; an rdy_m pulse outside BUSY is ignored.
  always_comb begin
    rdy_a = '0;
    if ((state_q == BUSY) && rdy_m && !reset) begin
      rdy_a[grant_idx_q] = 1'b1;
    end
  end

  assign din_a     = {NREQ{din_m}};
  assign addr_m    = addr_m_q;
  assign dout_m    = dout_m_q;
  assign wr_m      = wr_m_q;
  assign req_m     = (state_q == BUSY);
  assign busy      = (state_q == BUSY);
  assign grant_idx = grant_idx_q;

endmodule

// File: doc/arb_rr_param.md
Name: arb_rr_param

Overview:
Parametrised round-robin arbiter that multiplexes NREQ requester channels onto one memory-side master port. It is the successor to the fixed 4-channel, 64-bit arbiter, with generic channel count, address width and data width. It registers the winning request onto the master port and returns completion to the granted channel only. The block sits between the core-side request ports and the single memory interface.

Parameters:
NREQ, 4, number of requester channels (2..16)
AW, 64, address width per channel
DW, 64, data width per channel
IDXW, $clog2(NREQ), width of the grant index (derived; do not override)
MAX_LOCK, 4, maximum back-to-back locked transactions (ARB_LOCK_EN only)

Ports:
clk  in  1  clock; all logic is on the rising edge
reset  in  1  synchronous, active-high reset
addr_a  in  NREQ*AW  requester addresses; channel i occupies [AW*(i+1)-1 : AW*i]
dout_a  in  NREQ*DW  requester write data, packed the same way
din_a  out  NREQ*DW  read data returned to the requesters
req_a  in  NREQ  request, one bit per channel
wr_a  in  NREQ  1 = write, 0 = read
rdy_a  out  NREQ  completion strobe, one bit per channel
lock_a  in  NREQ  lock request (used only with ARB_LOCK_EN; ignored otherwise)
addr_m  out  AW  master address
dout_m  out  DW  master write data
din_m  in  DW  master read data
req_m  out  1  master request
wr_m  out  1  master write enable
rdy_m  in  1  master completion
grant_idx  out  IDXW  index of the currently granted channel
busy  out  1  a transaction is in progress

Behaviour:
- Two-state FSM: IDLE and BUSY.
- Reset values: state = IDLE, last = NREQ-1 (so channel 0 has first priority), grant_idx = 0, busy = 0, req_m = 0, wr_m = 0, addr_m = 0, dout_m = 0, rdy_a = 0.
- Arbitration in IDLE:
  - Search req_a starting at channel (last+1) mod NREQ and wrapping; the first set bit wins.
  - On a winner at edge k: grant_idx <= winner; addr_m, dout_m and wr_m are registered from the winner's slices; req_m <= 1; busy <= 1; state <= BUSY.
  - req_m is therefore asserted in cycle k+1 (one-cycle grant latency).
  - If no request is set, the FSM stays in IDLE and req_m stays 0.
- BUSY:
  - addr_m, dout_m and wr_m are held stable regardless of changes on the requester side.
  - rdy_a[grant_idx] = rdy_m (combinational) while BUSY; every other rdy_a bit is 0.
  - din_a is din_m replicated into every channel slice; the data is valid only for the channel whose rdy_a is asserted.
  - On rdy_m = 1: last <= grant_idx, req_m <= 0, busy <= 0, state <= IDLE.
  - A rdy_m pulse while in IDLE is ignored; no rdy_a bit is asserted.
- Requester rule: hold req_a[i] and its address, data and wr until rdy_a[i] is seen. The requester samples din_a on that same cycle.
- Turnaround: at least one IDLE cycle between transactions. Back-to-back grants are therefore spaced 2 cycles apart, rdy_m to next req_m.
- Fairness: a channel that requests continuously is granted within NREQ transactions.
- Simultaneous events: requests are only sampled in IDLE. A request arriving on the same edge as rdy_m is evaluated in the following IDLE cycle.
- Reset mid-transaction: the FSM returns to IDLE, req_m goes to 0 on the next edge, and the pending transaction is dropped with no rdy_a.

Optional Feature:
ARB_LOCK_EN
- Defined:
  - If lock_a[grant_idx] = 1 on the rdy_m cycle and the lock count is below MAX_LOCK, last is not updated.
  - The next IDLE cycle grants the same channel, provided its req_a bit is set, ahead of round-robin order.
  - The lock counter increments on each locked grant. It clears on any unlocked grant, and when it reaches MAX_LOCK the next arbitration is forced to round-robin.
- Undefined: lock_a is unused and arbitration is pure round-robin.

Test Plan:
- Reset, then req_a = 4'b0001 with addr slice 0 = 0x100 and wr = 0 -> req_m = 1 one cycle later, addr_m = 0x100. din_m = 0xAA with rdy_m = 1 -> rdy_a = 4'b0001, din_a slice 0 = 0xAA.
- req_a = 4'b1111 held, with rdy_m returned 2 cycles after each req_m -> grant_idx sequence 0,1,2,3,0.
- Grant channel 2, then change addr_a slice 2 while BUSY -> addr_m keeps its captured value until rdy_m.
- Assert reset while BUSY on channel 1 -> req_m = 0, busy = 0 and rdy_a = 0 next cycle; the first post-reset grant goes to channel 0 when all channels request.
- rdy_m pulsed in IDLE with req_a = 0 -> rdy_a stays 4'b0000 and the state stays IDLE.
- With ARB_LOCK_EN, req_a = 4'b0011 and lock_a = 4'b0001 -> channel 0 granted 4 times, then channel 1.
